// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the alu arbiter: alu control codes and arbiter FSM state encodings.
package alu_arbiter_pkg;

   localparam int CTRL_W = 4;

   // alu control codes
   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_SLL  = 4'h2;
   localparam logic [3:0] ALU_SLT  = 4'h3;
   localparam logic [3:0] ALU_SLTU = 4'h4;
   localparam logic [3:0] ALU_XOR  = 4'h5;
   localparam logic [3:0] ALU_SRL  = 4'h6;
   localparam logic [3:0] ALU_SRA  = 4'h7;
   localparam logic [3:0] ALU_OR   = 4'h8;
   localparam logic [3:0] ALU_AND  = 4'h9;

   // arbiter FSM states
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_EXEC = 2'd1,
      ARB_RESP = 2'd2
   } arbState_e;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid requester after lastGrant, wrapping modulo NUM_REQ.
module rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   lastGrant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grantIdx
);

   logic [NUM_REQ-1:0] grant_s;
   logic [IDX_W-1:0]   grantIdx_s;

   // Search lastGrant+1 .. lastGrant+NUM_REQ; the first valid hit wins.
   always_comb begin
      logic found_s;
      int   pos_s;
      grant_s    = {NUM_REQ{1'b0}};
      grantIdx_s = {IDX_W{1'b0}};
      found_s    = 1'b0;
      pos_s      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         pos_s = int'(lastGrant) + k;
         if (pos_s >= NUM_REQ) begin
            pos_s = pos_s - NUM_REQ;
         end else begin
            pos_s = pos_s;
         end
         if (!found_s && valid[pos_s]) begin
            found_s        = 1'b1;
            grant_s[pos_s] = 1'b1;
            grantIdx_s     = IDX_W'(pos_s);
         end else begin
            found_s = found_s;
         end
      end
   end

   assign grant    = grant_s;
   assign grantIdx = grantIdx_s;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between NUM_REQ requesters. Operands are registered
// before the alu and the result after it; one op in flight, round-robin grant.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       reqValid,
   output logic [NUM_REQ-1:0]       reqReady,
   input  logic [NUM_REQ*WIDTH-1:0] reqIn1,
   input  logic [NUM_REQ*WIDTH-1:0] reqIn2,
   input  logic [NUM_REQ*4-1:0]     reqCtrl,
   output logic [NUM_REQ-1:0]       rspValid,
   input  logic [NUM_REQ-1:0]       rspReady,
   output logic [WIDTH-1:0]         rspOut,
   output logic                     rspZero,
   output logic [WIDTH-1:0]         aluIn1,
   output logic [WIDTH-1:0]         aluIn2,
   output logic [3:0]               aluControl,
   input  logic [WIDTH-1:0]         aluOut,
   input  logic                     zeroFlag
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arbState_e          state_r;
   arbState_e          nextState_s;
   logic [IDX_W-1:0]   owner_r;
   logic [IDX_W-1:0]   lastGrant_r;
   logic [NUM_REQ-1:0] grant_s;
   logic [IDX_W-1:0]   grantIdx_s;
   logic [NUM_REQ-1:0] reqReady_s;
   logic               accept_s;
   logic [NUM_REQ-1:0] ownerOneHot_s;
   logic [NUM_REQ-1:0] rspValid_r;
   logic [WIDTH-1:0]   rspOut_r;
   logic               rspZero_r;
   logic [WIDTH-1:0]   aluIn1_r;
   logic [WIDTH-1:0]   aluIn2_r;
   logic [3:0]         aluControl_r;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) uPicker (
      .valid     (reqValid),
      .lastGrant (lastGrant_r),
      .grant     (grant_s),
      .grantIdx  (grantIdx_s)
   );

   assign ownerOneHot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;

   // Next-state and grant: a new op may be taken in IDLE, or in RESP in the same
   // cycle the owner takes its result (back-to-back path).
   always_comb begin
      nextState_s = state_r;
      reqReady_s  = {NUM_REQ{1'b0}};
      case (state_r)
         ARB_IDLE: begin
            reqReady_s = grant_s;
            if (|(reqValid & grant_s)) begin
               nextState_s = ARB_EXEC;
            end else begin
               nextState_s = ARB_IDLE;
            end
         end
         ARB_EXEC: begin
            nextState_s = ARB_RESP;
         end
         ARB_RESP: begin
            if (rspReady[owner_r]) begin
               reqReady_s = grant_s;
               if (|(reqValid & grant_s)) begin
                  nextState_s = ARB_EXEC;
               end else begin
                  nextState_s = ARB_IDLE;
               end
            end else begin
               nextState_s = ARB_RESP;
            end
         end
         default: begin
            nextState_s = ARB_IDLE;
         end
      endcase
   end

   assign accept_s = |(reqValid & reqReady_s);

   // State, owner and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ARB_IDLE;
         owner_r     <= {IDX_W{1'b0}};
         lastGrant_r <= IDX_W'(NUM_REQ - 1);
      end else begin
         state_r <= nextState_s;
         if (accept_s) begin
            owner_r     <= grantIdx_s;
            lastGrant_r <= grantIdx_s;
         end else begin
            owner_r     <= owner_r;
            lastGrant_r <= lastGrant_r;
         end
      end
   end

   // Operand/control registers feeding the alu; loaded only on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aluIn1_r     <= {WIDTH{1'b0}};
         aluIn2_r     <= {WIDTH{1'b0}};
         aluControl_r <= ALU_ADD;
      end else if (accept_s) begin
         aluIn1_r     <= reqIn1[int'(grantIdx_s)*WIDTH +: WIDTH];
         aluIn2_r     <= reqIn2[int'(grantIdx_s)*WIDTH +: WIDTH];
         aluControl_r <= reqCtrl[int'(grantIdx_s)*4 +: 4];
      end else begin
         aluIn1_r     <= aluIn1_r;
         aluIn2_r     <= aluIn2_r;
         aluControl_r <= aluControl_r;
      end
   end

   // Result capture at the end of EXEC; held until the owner accepts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rspOut_r   <= {WIDTH{1'b0}};
         rspZero_r  <= 1'b0;
         rspValid_r <= {NUM_REQ{1'b0}};
      end else if (state_r == ARB_EXEC) begin
         rspOut_r   <= aluOut;
         rspZero_r  <= zeroFlag;
         rspValid_r <= ownerOneHot_s;
      end else if ((state_r == ARB_RESP) && rspReady[owner_r]) begin
         rspOut_r   <= rspOut_r;
         rspZero_r  <= rspZero_r;
         rspValid_r <= {NUM_REQ{1'b0}};
      end else begin
         rspOut_r   <= rspOut_r;
         rspZero_r  <= rspZero_r;
         rspValid_r <= rspValid_r;
      end
   end

   assign reqReady   = reqReady_s;
   assign rspValid   = rspValid_r;
   assign rspOut     = rspOut_r;
   assign rspZero    = rspZero_r;
   assign aluIn1     = aluIn1_r;
   assign aluIn2     = aluIn2_r;
   assign aluControl = aluControl_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural stand-in for the neighbouring alu.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   localparam int NR = 2;
   localparam int W  = 32;

   logic            clk;
   logic            rst_n;
   logic [NR-1:0]   reqValid;
   logic [NR-1:0]   reqReady;
   logic [NR*W-1:0] reqIn1;
   logic [NR*W-1:0] reqIn2;
   logic [NR*4-1:0] reqCtrl;
   logic [NR-1:0]   rspValid;
   logic [NR-1:0]   rspReady;
   logic [W-1:0]    rspOut;
   logic            rspZero;
   logic [W-1:0]    aluIn1;
   logic [W-1:0]    aluIn2;
   logic [3:0]      aluControl;
   logic [W-1:0]    aluOut;
   logic            zeroFlag;

   int checkCount = 0;
   int errCount   = 0;

   alu_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .reqValid   (reqValid),
      .reqReady   (reqReady),
      .reqIn1     (reqIn1),
      .reqIn2     (reqIn2),
      .reqCtrl    (reqCtrl),
      .rspValid   (rspValid),
      .rspReady   (rspReady),
      .rspOut     (rspOut),
      .rspZero    (rspZero),
      .aluIn1     (aluIn1),
      .aluIn2     (aluIn2),
      .aluControl (aluControl),
      .aluOut     (aluOut),
      .zeroFlag   (zeroFlag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural alu: undefined codes return 0.
   always_comb begin
      aluOut = 32'd0;
      case (aluControl)
         ALU_ADD:  aluOut = aluIn1 + aluIn2;
         ALU_SUB:  aluOut = aluIn1 - aluIn2;
         ALU_SLL:  aluOut = aluIn1 << aluIn2[4:0];
         ALU_SLT:  aluOut = {31'd0, ($signed(aluIn1) < $signed(aluIn2))};
         ALU_SLTU: aluOut = {31'd0, (aluIn1 < aluIn2)};
         ALU_XOR:  aluOut = aluIn1 ^ aluIn2;
         ALU_SRL:  aluOut = aluIn1 >> aluIn2[4:0];
         ALU_SRA:  aluOut = $unsigned($signed(aluIn1) >>> aluIn2[4:0]);
         ALU_OR:   aluOut = aluIn1 | aluIn2;
         ALU_AND:  aluOut = aluIn1 & aluIn2;
         default:  aluOut = 32'd0;
      endcase
   end
   assign zeroFlag = (aluOut == 32'd0);

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input int i, input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
      reqIn1[i*W +: W] = a;
      reqIn2[i*W +: W] = b;
      reqCtrl[i*4 +: 4] = ctrl;
   endtask

   // Single op from requester i starting in IDLE with rspReady held high.
   task automatic doOp(input string tag, input int i, input logic [3:0] ctrl,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expOut, input logic expZero);
      logic [1:0] oh;
      oh = 2'b01 << i;
      setReq(i, ctrl, a, b);
      reqValid = oh;
      #1;
      checkEq({tag, "_reqReady"}, 64'(reqReady), 64'(oh));
      tick();
      reqValid = 2'b00;
      #1;
      checkEq({tag, "_execReady"}, 64'(reqReady), 64'd0);
      tick();
      checkEq({tag, "_rspValid"}, 64'(rspValid), 64'(oh));
      checkEq({tag, "_rspOut"}, 64'(rspOut), 64'(expOut));
      checkEq({tag, "_rspZero"}, 64'(rspZero), 64'(expZero));
      tick();
      checkEq({tag, "_idleValid"}, 64'(rspValid), 64'd0);
   endtask

   initial begin
      logic [1:0] expOh;
      rst_n    = 1'b0;
      reqValid = 2'b00;
      rspReady = 2'b00;
      reqIn1   = '0;
      reqIn2   = '0;
      reqCtrl  = '0;
      #2;
      checkEq("reset_outs", {rspValid, rspOut, rspZero, aluControl, reqReady},
              64'd0);
      checkEq("reset_aluIn", {aluIn1, aluIn2}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // 1: req0 ADD 5,7
      setReq(0, ALU_ADD, 32'd5, 32'd7);
      reqValid = 2'b01;
      #1;
      checkEq("t1_accept", 64'(reqReady), 64'h1);
      tick();
      reqValid = 2'b00;
      #1;
      checkEq("t1_n1_ready", 64'(reqReady), 64'h0);
      checkEq("t1_n1_valid", 64'(rspValid), 64'h0);
      checkEq("t1_aluIn1", 64'(aluIn1), 64'd5);
      checkEq("t1_aluIn2", 64'(aluIn2), 64'd7);
      tick();
      checkEq("t1_rspValid", 64'(rspValid), 64'h1);
      checkEq("t1_rspOut", 64'(rspOut), 64'd12);
      checkEq("t1_rspZero", 64'(rspZero), 64'd0);
      rspReady = 2'b01;
      tick();
      checkEq("t1_done", 64'(rspValid), 64'h0);

      // 2: both valid right after reset; req0 first, then req1 back-to-back
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      rspReady = 2'b11;
      setReq(0, ALU_SUB, 32'd3, 32'd3);
      setReq(1, ALU_OR, 32'h000000F0, 32'h0000000F);
      reqValid = 2'b11;
      #1;
      checkEq("t2_grant0", 64'(reqReady), 64'h1);
      tick();
      reqValid = 2'b10;
      #1;
      checkEq("t2_exec_ready", 64'(reqReady), 64'h0);
      tick();
      checkEq("t2_rsp0_valid", 64'(rspValid), 64'h1);
      checkEq("t2_rsp0_out", 64'(rspOut), 64'd0);
      checkEq("t2_rsp0_zero", 64'(rspZero), 64'd1);
      checkEq("t2_grant1", 64'(reqReady), 64'h2);
      tick();
      reqValid = 2'b00;
      tick();
      checkEq("t2_rsp1_valid", 64'(rspValid), 64'h2);
      checkEq("t2_rsp1_out", 64'(rspOut), 64'hFF);
      checkEq("t2_rsp1_zero", 64'(rspZero), 64'd0);
      tick();

      // 3: response stall; non-owner rspReady ignored; release accepts same cycle
      setReq(0, ALU_ADD, 32'd1, 32'd2);
      reqValid = 2'b01;
      #1;
      checkEq("t3_accept", 64'(reqReady), 64'h1);
      tick();
      setReq(1, ALU_XOR, 32'hA, 32'h5);
      reqValid = 2'b10;
      rspReady = 2'b10;
      tick();
      for (int c = 0; c < 5; c++) begin
         checkEq("t3_hold_valid", 64'(rspValid), 64'h1);
         checkEq("t3_hold_out", 64'(rspOut), 64'd3);
         checkEq("t3_hold_ready", 64'(reqReady), 64'h0);
         tick();
      end
      rspReady = 2'b01;
      #1;
      checkEq("t3_release_ready", 64'(reqReady), 64'h2);
      tick();
      reqValid = 2'b00;
      rspReady = 2'b11;
      tick();
      checkEq("t3_rsp1_valid", 64'(rspValid), 64'h2);
      checkEq("t3_rsp1_out", 64'(rspOut), 64'hF);
      tick();

      // 4: both valid for 6 ops, alternating grants every 2 cycles
      setReq(0, ALU_ADD, 32'd10, 32'd1);
      setReq(1, ALU_SUB, 32'd10, 32'd1);
      reqValid = 2'b11;
      #1;
      for (int k = 0; k < 6; k++) begin
         expOh = (k % 2 == 0) ? 2'b01 : 2'b10;
         checkEq("t4_grant", 64'(reqReady), 64'(expOh));
         tick();
         checkEq("t4_exec_ready", 64'(reqReady), 64'h0);
         tick();
         checkEq("t4_rsp_valid", 64'(rspValid), 64'(expOh));
         checkEq("t4_rsp_out", 64'(rspOut), (k % 2 == 0) ? 64'd11 : 64'd9);
         if (k == 5) begin
            reqValid = 2'b00;
         end else begin
            reqValid = 2'b11;
         end
         #1;
      end
      tick();
      checkEq("t4_idle", 64'(rspValid), 64'h0);

      // 5: reset during EXEC clears outputs immediately
      setReq(0, ALU_ADD, 32'd4, 32'd4);
      reqValid = 2'b01;
      tick();
      reqValid = 2'b00;
      #1;
      rst_n = 1'b0;
      #1;
      checkEq("t5_rst_outs", {rspValid, rspOut, rspZero, aluControl, reqReady}, 64'd0);
      checkEq("t5_rst_aluIn", {aluIn1, aluIn2}, 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      checkEq("t5_no_rsp", 64'(rspValid), 64'h0);
      doOp("t5_op", 0, ALU_ADD, 32'd6, 32'd7, 32'd13, 1'b0);

      // 6: comparisons and undefined code from a sole requester
      doOp("t6_slt", 1, ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
      doOp("t6_sltu", 1, ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
      doOp("t6_undef", 1, 4'hF, 32'd9, 32'd9, 32'd0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
      $finish;
   end

endmodule
